// File: rtl/spi_cmd_ctl.sv
// spi_cmd_ctl: decodes SPI command/data bytes into register writes, register
//   read addressing and per-channel LED RAM writes.
// Latency: every strobe and address appears exactly one cycle after its byte.
// Backpressure: none; a byte arrives at most once per cycle and is always consumed.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   dc_i                    0 = command byte, 1 = data byte
//   spi_cs_n_i              chip select (active low, already synchronised)
//   spi_byte_vld_i/_data_i  received byte strobe and value
//   reg_rd_addr_o           register read address for the SPI transmit byte
//   reg_wr_en_o/_addr_o     register write strobe and address
//   ram_wr_en_o             one-hot per-channel RAM write strobe
//   ram_wr_addr_o/_data_o   shared RAM write address and data
//   cmd_err_o               pulse on unknown command or bad channel index
module spi_cmd_ctl #(
  parameter int CH_NUM    = 8,
  parameter int REG_NUM   = 8,
  parameter int RAM_DEPTH = 1024,
  localparam int REG_AW   = $clog2(REG_NUM),
  localparam int RAM_AW   = $clog2(RAM_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dc_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_byte_vld_i,
  input  logic [7:0]        spi_byte_data_i,
  output logic [REG_AW-1:0] reg_rd_addr_o,
  output logic              reg_wr_en_o,
  output logic [REG_AW-1:0] reg_wr_addr_o,
  output logic [CH_NUM-1:0] ram_wr_en_o,
  output logic [RAM_AW-1:0] ram_wr_addr_o,
  output logic [7:0]        ram_wr_data_o,
  output logic              cmd_err_o
);

  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_INFO_RD = 8'h3A;
  localparam logic [7:0] CMD_CHAN    = 8'h2B;

  // Write pointer carries one extra bit so "all REG_NUM registers written"
  // is distinguishable from pointer 0; once full, further data is dropped.
  localparam logic [REG_AW:0] PTR_FULL = (REG_AW+1)'(REG_NUM);

  typedef enum logic [2:0] {
    IDLE,
    CONF_WR,
    INFO_RD,
    CHAN_SEL,
    CHAN_WR
  } state_t;

  state_t            state_q, state_d;
  logic [REG_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [REG_AW-1:0] rd_addr_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ch_idx_q, ch_idx_d;
  logic              reg_wr_en_d;
  logic [REG_AW-1:0] reg_wr_addr_d;
  logic [CH_NUM-1:0] ram_wr_en_d;
  logic [RAM_AW-1:0] ram_wr_addr_d;
  logic [7:0]        ram_wr_data_d;
  logic              cmd_err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      ram_addr_q    <= '0;
      ch_idx_q      <= '0;
      reg_rd_addr_o <= '0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= '0;
      ram_wr_en_o   <= '0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
      cmd_err_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      ram_addr_q    <= ram_addr_d;
      ch_idx_q      <= ch_idx_d;
      reg_rd_addr_o <= rd_addr_d;
      reg_wr_en_o   <= reg_wr_en_d;
      reg_wr_addr_o <= reg_wr_addr_d;
      ram_wr_en_o   <= ram_wr_en_d;
      ram_wr_addr_o <= ram_wr_addr_d;
      ram_wr_data_o <= ram_wr_data_d;
      cmd_err_o     <= cmd_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_addr_d     = reg_rd_addr_o;
    ram_addr_d    = ram_addr_q;
    ch_idx_d      = ch_idx_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_addr_d = reg_wr_addr_o;
    ram_wr_en_d   = '0;
    ram_wr_addr_d = ram_wr_addr_o;
    ram_wr_data_d = ram_wr_data_o;
    cmd_err_d     = 1'b0;

    if (spi_cs_n_i) begin
      // Deselect aborts the transfer; a byte in this cycle is discarded and
      // pointers keep their values until the next command clears them.
      state_d = IDLE;
    end else if (spi_byte_vld_i) begin
      if (!dc_i) begin
        wr_ptr_d   = '0;
        rd_addr_d  = '0;
        ram_addr_d = '0;
        case (spi_byte_data_i)
          CMD_CONF_WR: state_d = CONF_WR;
          CMD_INFO_RD: state_d = INFO_RD;
          CMD_CHAN:    state_d = CHAN_SEL;
          default: begin
            state_d   = IDLE;
            cmd_err_d = 1'b1;
          end
        endcase
      end else begin
        case (state_q)
          CONF_WR: begin
            if (wr_ptr_q != PTR_FULL) begin
              reg_wr_en_d   = 1'b1;
              reg_wr_addr_d = wr_ptr_q[REG_AW-1:0];
              wr_ptr_d      = wr_ptr_q + (REG_AW+1)'(1);
            end
          end
          INFO_RD: begin
            // REG_NUM is a power of two, so natural overflow wraps to 0.
            rd_addr_d = reg_rd_addr_o + REG_AW'(1);
          end
          CHAN_SEL: begin
            ch_idx_d = spi_byte_data_i;
            if (int'(spi_byte_data_i) < CH_NUM) begin
              state_d = CHAN_WR;
            end else begin
              state_d   = IDLE;
              cmd_err_d = 1'b1;
            end
          end
          CHAN_WR: begin
            for (int i = 0; i < CH_NUM; i++) begin
              ram_wr_en_d[i] = (ch_idx_q == 8'(i));
            end
            ram_wr_addr_d = ram_addr_q;
            ram_wr_data_d = spi_byte_data_i;
            ram_addr_d    = ram_addr_q + RAM_AW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spi_cmd_ctl.md
SPI_CMD_CTL -- requirements
Module: spi_cmd_ctl

Interface
REQ-001 Parameter CH_NUM, 8, number of LED output channels (1..16) SHALL be supported.
REQ-002 Parameter REG_NUM, 8, number of configuration registers (power of two, 2..256) SHALL be supported.
REQ-003 Parameter RAM_DEPTH, 1024, bytes per channel RAM (power of two) SHALL be supported; RAM_AW = log2(RAM_DEPTH), REG_AW = log2(REG_NUM).
REQ-004 Port clk_i, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst_i, input, 1, synchronous active-high reset.
REQ-006 Port dc_i, input, 1, 0 = command byte, 1 = data byte.
REQ-007 Port spi_cs_n_i, input, 1, SPI chip select, active low, synchronised to clk_i upstream.
REQ-008 Port spi_byte_vld_i, input, 1, one-cycle pulse per received byte.
REQ-009 Port spi_byte_data_i, input, 8, received byte.
REQ-010 Port reg_rd_addr_o, output, REG_AW, register read address feeding the SPI transmit byte.
REQ-011 Port reg_wr_en_o / reg_wr_addr_o, output, 1 / REG_AW, register write strobe and address.
REQ-012 Port ram_wr_en_o, output, CH_NUM, one-hot per-channel RAM write strobe.
REQ-013 Port ram_wr_addr_o / ram_wr_data_o, output, RAM_AW / 8, shared RAM write address and data.
REQ-014 Port cmd_err_o, output, 1, one-cycle pulse on unknown command or out-of-range channel.

Function
REQ-015 States SHALL be IDLE, CONF_WR, INFO_RD, CHAN_SEL, CHAN_WR.
REQ-016 Byte with dc_i=0 SHALL decode in any state: 0x2A->CONF_WR, 0x3A->INFO_RD, 0x2B->CHAN_SEL, other->IDLE plus cmd_err_o pulse.
REQ-017 Each command byte SHALL reset the register pointer and the RAM address to 0.
REQ-018 CONF_WR: each data byte SHALL drive reg_wr_en_o=1 for one cycle with reg_wr_addr_o=pointer; pointer then increments.
REQ-019 CONF_WR: after REG_NUM data bytes, further data bytes SHALL be ignored (no wrap, no error).
REQ-020 INFO_RD: reg_rd_addr_o SHALL be 0 on entry and increment by 1 per data byte, wrapping REG_NUM-1->0.
REQ-021 CHAN_SEL: first data byte SHALL latch the channel index; index < CH_NUM -> CHAN_WR; otherwise -> IDLE plus cmd_err_o pulse.
REQ-022 CHAN_WR: each data byte SHALL assert ram_wr_en_o[index] only, ram_wr_data_o=byte, ram_wr_addr_o=address; address then increments, wrapping RAM_DEPTH-1->0.
REQ-023 Data bytes in IDLE SHALL be ignored.
REQ-024 All outputs SHALL be registered; strobes SHALL be asserted exactly the cycle after the spi_byte_vld_i cycle.
REQ-025 spi_cs_n_i=1 SHALL force IDLE next cycle and suppress any strobe for a byte in the same cycle; pointers are held until the next command.
REQ-026 Cycles without spi_byte_vld_i SHALL hold the state, pointers and addresses.

Reset
REQ-027 rst_i=1 SHALL force the state to IDLE, all addresses and the channel index to 0, and all strobes plus cmd_err_o to 0 on the next edge, including mid-transfer.
REQ-028 The first byte after reset release SHALL be decoded normally with no stale strobe.

Verification
REQ-029 CONF_WR 0x2A, then 10 data bytes 0xFF (REG_NUM=8) -> 8 reg_wr_en_o pulses, addresses 0..7; bytes 9-10 produce no pulse.
REQ-030 INFO_RD 0x3A, then 10 data bytes 0x00 -> reg_rd_addr_o sequence 0,1..7,0,1,2; reg_wr_en_o stays 0.
REQ-031 0x2B, data 0x03, then bytes 0x11,0x22 -> ram_wr_en_o=0x08 twice, addresses 0,1, data 0x11,0x22.
REQ-032 0x2B, data 0x09 (CH_NUM=8) -> cmd_err_o single pulse, state IDLE; a following data byte gives no strobe.
REQ-033 RAM_DEPTH=4, channel 0, 6 data bytes -> ram_wr_addr_o 0,1,2,3,0,1.
REQ-034 CHAN_WR mid-stream: rst_i pulse, or spi_cs_n_i=1 coincident with a byte -> no strobe for that byte, state IDLE, later bytes ignored until a new command.
